e_mdu_ctrl: RTL and testbench

Execute-stage multiply/divide controller for the five-stage MIPS pipeline. It accepts MDU-class instructions presented in E, owns the HI/LO registers and sequences multi-cycle mult/div operations. It drives the `start`/`BUSY` pair consumed by the D/E pipeline register and the hazard unit, and it produces the stall request for MDU instructions waiting in D. Exception requests (`Req`) cancel any E-stage MDU instruction before it commits.

---
 rtl/e_mdu_ctrl_if.sv | 25 ++
 rtl/e_mdu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_e_mdu_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_ctrl_if.sv
// E-stage MDU interface: instruction/operand inputs, start/BUSY handshake,
// hazard stall request and HI/LO read-back.
interface e_mdu_ctrl_if;
    logic [3:0]  op_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        md_D;
    logic        Req;
    logic        start;
    logic        BUSY;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rdata_E;

    modport master (
        output op_E, A_E, B_E, md_D, Req,
        input  start, BUSY, stall_md, HI, LO, rdata_E
    );

    modport slave (
        input  op_E, A_E, B_E, md_D, Req,
        output start, BUSY, stall_md, HI, LO, rdata_E
    );
endinterface

// File: rtl/e_mdu_ctrl.sv
// Execute-stage multiply/divide controller: owns HI/LO and sequences mult/div.
// Optional MDU_DIVZERO_SKIP_EN: divide-by-zero completes without entering RUN.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    e_mdu_ctrl_if.slave mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    mdu_op_t            op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    logic               busy;
    logic               is_md_op;
    logic               is_mul_op;
    logic               start;
    logic               skip_run;
    logic [CNT_W-1:0]   run_len;
    logic [31:0]        rdata;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               b_zero;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        den_s;
    logic [31:0]        den_u;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;

    assign busy      = (state == S_RUN);
    assign is_mul_op = (mdu.op_E == OP_MULT) || (mdu.op_E == OP_MULTU);
    assign is_md_op  = is_mul_op || (mdu.op_E == OP_DIV) || (mdu.op_E == OP_DIVU);
    assign start     = reset & ~busy & ~mdu.Req & is_md_op;
    assign run_len   = is_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

`ifdef MDU_DIVZERO_SKIP_EN
    assign skip_run = ((mdu.op_E == OP_DIV) || (mdu.op_E == OP_DIVU)) && (mdu.B_E == '0);
`else
    assign skip_run = 1'b0;
`endif

    // Both products come from 64-bit operands so the low 64 bits are exact.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'h0, a_q} * {32'h0, b_q};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign b_zero = (b_q == '0);
    assign a_mag  = a_q[31] ? -a_q : a_q;
    assign b_mag  = b_q[31] ? -b_q : b_q;
    assign den_s  = b_zero ? 32'd1 : b_mag;
    assign den_u  = b_zero ? 32'd1 : b_q;
    assign mag_q  = a_mag / den_s;
    assign mag_r  = a_mag % den_s;
    assign quo_s  = (a_q[31] ^ b_q[31]) ? -mag_q : mag_q;
    assign rem_s  = a_q[31] ? -mag_r : mag_r;
    assign quo_u  = a_q / den_u;
    assign rem_u  = a_q % den_u;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= mdu_op_t'(mdu.op_E);
                        a_q  <= mdu.A_E;
                        b_q  <= mdu.B_E;
                        if (!skip_run) begin
                            cnt   <= run_len;
                            state <= S_RUN;
                        end
                    end else if (!mdu.Req && (mdu.op_E == OP_MTHI)) begin
                        hi_q <= mdu.A_E;
                    end else if (!mdu.Req && (mdu.op_E == OP_MTLO)) begin
                        lo_q <= mdu.A_E;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        case (op_q)
                            OP_MULT: begin
                                hi_q <= prod_s[63:32];
                                lo_q <= prod_s[31:0];
                            end
                            OP_MULTU: begin
                                hi_q <= prod_u[63:32];
                                lo_q <= prod_u[31:0];
                            end
                            OP_DIV: begin
                                if (!b_zero) begin
                                    hi_q <= rem_s;
                                    lo_q <= quo_s;
                                end
                            end
                            OP_DIVU: begin
                                if (!b_zero) begin
                                    hi_q <= rem_u;
                                    lo_q <= quo_u;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (reset) begin
            if (mdu.op_E == OP_MFHI) begin
                rdata = hi_q;
            end else if (mdu.op_E == OP_MFLO) begin
                rdata = lo_q;
            end
        end
    end

    assign mdu.start    = start;
    assign mdu.BUSY     = busy;
    assign mdu.stall_md = reset & mdu.md_D & (start | busy);
    assign mdu.HI       = hi_q;
    assign mdu.LO       = lo_q;
    assign mdu.rdata_E  = rdata;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: vector table, corner sequences and a
// randomized run against a cycle-timestamped behavioural model.
module tb_e_mdu_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

`ifdef MDU_DIVZERO_SKIP_EN
    localparam int DZ_BUSY = 0;
`else
    localparam int DZ_BUSY = DIV_N;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    e_mdu_ctrl_if mdu();

    e_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk  (clk),
        .reset(reset),
        .mdu  (mdu)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: HI/LO plus the cycle index of the last BUSY cycle of a pending op.
    int          cyc = 0;
    int          m_end = -1;
    logic        m_pend = 1'b0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          m_init = 1'b0;

    logic        last_start;
    logic        last_stall;
    logic [31:0] last_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return 64'h0;
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic md, input logic req, input logic rst);
        logic        busy;
        logic        e_start;
        logic        dz;
        logic        skip;
        logic [31:0] e_rdata;
        int          n;
        mdu.op_E = op;
        mdu.A_E  = a;
        mdu.B_E  = b;
        mdu.md_D = md;
        mdu.Req  = req;
        reset    = rst;
        #1;
        busy    = (cyc <= m_end);
        e_start = rst && !busy && !req && (op >= 4'd1) && (op <= 4'd4);
        e_rdata = !rst ? 32'h0 : (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
        last_start = mdu.start;
        last_stall = mdu.stall_md;
        last_rdata = mdu.rdata_E;
        check("start", {31'b0, mdu.start}, {31'b0, e_start});
        if (m_init) begin
            check("BUSY", {31'b0, mdu.BUSY}, {31'b0, busy});
            check("stall_md", {31'b0, mdu.stall_md}, {31'b0, rst && md && (e_start || busy)});
            check("rdata_E", mdu.rdata_E, e_rdata);
            check("HI", mdu.HI, m_hi);
            check("LO", mdu.LO, m_lo);
        end
        @(posedge clk);
        if (!rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_end  = -1;
            m_pend = 1'b0;
            m_init = 1'b1;
        end else begin
            if (busy && cyc == m_end && m_pend) {m_hi, m_lo} = m_res;
            if (e_start) begin
                dz   = (op == 4'd3 || op == 4'd4) && b == 0;
                n    = (op <= 4'd2) ? MULT_N : DIV_N;
                skip = 1'b0;
`ifdef MDU_DIVZERO_SKIP_EN
                skip = dz;
`endif
                if (!skip) begin
                    m_end  = cyc + n;
                    m_pend = !dz;
                    m_res  = ref_result(op, a, b);
                end
            end else if (!busy && !req) begin
                if (op == 4'd5) m_hi = a;
                if (op == 4'd6) m_lo = a;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input logic md);
        step(4'd0, 32'h0, 32'h0, md, 1'b0, 1'b1);
    endtask

    // Issue one op, then idle until BUSY drops; returns the BUSY cycle count.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic md, output int nbusy);
        step(op, a, b, md, 1'b0, 1'b1);
        nbusy = 0;
        while (mdu.BUSY && nbusy < 40) begin
            idle(md);
            nbusy++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t tbl[11];
        int   nb;
        int   nstall;
        logic [3:0] rop;

        tbl[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
        tbl[1]  = '{4'd4, 32'd17,        32'd5,        32'd2,         32'd3,         DIV_N};
        tbl[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
        tbl[3]  = '{4'd5, 32'h11,        32'd0,        32'h11,        32'hFFFF_FFFD, 0};
        tbl[4]  = '{4'd6, 32'h22,        32'd0,        32'h11,        32'h22,        0};
        tbl[5]  = '{4'd3, 32'd5,         32'd0,        32'h11,        32'h22,        DZ_BUSY};
        tbl[6]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, DIV_N};
        tbl[7]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
        tbl[8]  = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        MULT_N};
        tbl[9]  = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, DIV_N};
        tbl[10] = '{4'd4, 32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFFF, DIV_N};

        // Reset
        step(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("rst_BUSY", {31'b0, mdu.BUSY}, 32'h0);
        check("rst_HI", mdu.HI, 32'h0);
        check("rst_LO", mdu.LO, 32'h0);

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, nb);
            check($sformatf("tbl_busy[%0d]", i), 32'(nb), 32'(tbl[i].busy));
            check($sformatf("tbl_hi[%0d]", i), mdu.HI, tbl[i].hi);
            check($sformatf("tbl_lo[%0d]", i), mdu.LO, tbl[i].lo);
        end

        // Req in the issue cycle discards multu
        step(4'd2, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
        check("req_start", {31'b0, last_start}, 32'h0);
        check("req_BUSY", {31'b0, mdu.BUSY}, 32'h0);
        check("req_HI", mdu.HI, 32'h0);
        check("req_LO", mdu.LO, 32'hFFFF_FFFF);
        // Req during RUN does not cancel
        step(4'd2, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
        nb = 0;
        while (mdu.BUSY && nb < 40) begin
            step(4'd0, 32'h0, 32'h0, 1'b0, (nb == 1), 1'b1);
            nb++;
        end
        check("reqrun_busy", 32'(nb), 32'(MULT_N));
        check("reqrun_HI", mdu.HI, 32'h0);
        check("reqrun_LO", mdu.LO, 32'd35);

        // Stall for every BUSY cycle, then mflo in the first free cycle
        step(4'd1, 32'd3, 32'd4, 1'b1, 1'b0, 1'b1);
        nb = 0;
        nstall = 0;
        while (mdu.BUSY && nb < 40) begin
            idle(1'b1);
            if (last_stall) nstall++;
            nb++;
        end
        check("stall_cycles", 32'(nstall), 32'(MULT_N));
        step(4'd8, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("stall_release", {31'b0, last_stall}, 32'h0);
        check("mflo_rdata", last_rdata, 32'd12);

        // Reset in the third BUSY cycle aborts the run
        step(4'd1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        step(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("abort_BUSY", {31'b0, mdu.BUSY}, 32'h0);
        check("abort_HI", mdu.HI, 32'h0);
        check("abort_LO", mdu.LO, 32'h0);
        for (int k = 0; k < 8; k++) idle(1'b0);
        check("abort_HI_late", mdu.HI, 32'h0);
        check("abort_LO_late", mdu.LO, 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            step(rop, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
